keypad_input: RTL and testbench
===============================

# keypad_input

Hex keypad entry block: the input-side counterpart of the multiplexed seven-segment output. It scans a 4x4 active-low key matrix one row at a time, debounces, assembles two key presses into a byte (first key is the high nibble), and presents the byte to the CPU bus on request. It runs entirely on `sys_clk` and talks to the CPU through a level `enable` and a one-cycle `ack`.

## Interface
- `SCAN_WAIT`, 1000: `sys_clk` cycles each row is driven before its columns are sampled; minimum 3.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- `sys_clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rows`  out  4  matrix row drive; active-low, exactly one row low.
- `cols`  in  4  matrix column sense; active-low, pulled up externally, asynchronous.
- `enable`  in  1  CPU read request; drives `bus_out`.
- `ack`  in  1  one-cycle pulse; CPU has consumed the byte.
- `bus_out`  out  8  assembled byte when `enable` is high, else 8'h00.
- `data_ready`  out  1  a full byte is held.
- `overrun`  out  1  sticky; a key was accepted and dropped while `data_ready` was high.

## Operation
- Synchronizer: `cols` passes through two flops and is inverted, so bit = 1 means pressed.
- Row scan: a dwell counter counts 0..`SCAN_WAIT`-1. At terminal count, the synchronized columns are written to `snap[row*4 +: 4]`, the counter clears, and the row advances 0→1→2→3→0. `rows` = ~(1<<row).
- Key code = row*4 + col. Row 0 / col 0 is key 0; row 3 / col 3 is key F.
- Scan end is the cycle row 3 is sampled. At scan end, `snap` is compared with the previous scan's `snap`:
  - equal: the stable counter increments, saturating at `DEBOUNCE_SCANS`;
  - different: the stable counter resets to 1.
- Debounce FSM:
  - RELEASED→PRESSED: at scan end with the stable count reaching `DEBOUNCE_SCANS` and exactly one `snap` bit set. That key is accepted once, in that cycle.
  - PRESSED→RELEASED: at scan end with the stable count reaching `DEBOUNCE_SCANS` and `snap` all zero.
  - Multi-key snapshots are never accepted. In PRESSED, a debounced multi-key or different-key snapshot does not leave PRESSED and accepts nothing. Full release is required between presses.
- Assembly:
  - `entry[7:0]` and `nib` (0/1) are held internally.
  - Key accepted with `nib`=0: `entry` = {key, 4'h0}, `nib` = 1.
  - Key accepted with `nib`=1: `entry[3:0]` = key, `nib` = 0, `data_ready` = 1.
  - Key accepted while `data_ready`=1 and no `ack` in the same cycle: key dropped, `overrun` = 1.
- `ack`: clears `data_ready`, `entry`, and `overrun`. If `ack` and an acceptance coincide, `ack` applies first and the key becomes the high nibble of the next byte. `ack` with `data_ready`=0 has no effect.
- `bus_out` = `enable` ? `entry` : 8'h00. This is combinational, so it can be ORed onto the bus. The partial `entry` is visible when `data_ready`=0.
- Reset mid-scan or mid-entry discards everything. Reset values:
  - outputs: `rows`=4'b1110, `data_ready`=0, `overrun`=0, `bus_out`=8'h00;
  - internal: `entry`=0, `nib`=0, FSM=RELEASED, row=0, counters=0, `snap` and previous `snap`=0.

## Timing
- Full scan = 4·`SCAN_WAIT` cycles.
- A column change reaches `snap` 2 cycles after the synchronizer input, at that row's next sample point.
- Acceptance happens at the end of the `DEBOUNCE_SCANS`-th consecutive identical scan. `entry`, `nib`, `data_ready`, and `overrun` update on the next clock edge.
- `bus_out` follows `enable` and `entry` with zero latency.
- `ack` takes effect on the next edge, so `data_ready` is 0 in the following cycle.
- Minimum press-to-accept, from a clean start: `DEBOUNCE_SCANS`·4·`SCAN_WAIT` cycles plus sync latency.

## Test plan
Use `SCAN_WAIT`=4 and `DEBOUNCE_SCANS`=2 unless stated.
- Reset: hold `rst`. Require `rows`=1110, `data_ready`=0, and `bus_out`=00 with `enable`=1. Release reset; `rows` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Byte entry: press key 6 (row 1, col 2) for 3 scans, release for 3 scans, then press key A (row 2, col 2). Require `data_ready`=1 one cycle after the second acceptance; with `enable`=1, `bus_out`=8'h6A.
- Bounce: toggle key 3 every 5 cycles for 4 scans, then hold. Require nothing accepted during toggling and exactly one acceptance after 2 stable scans. Holding 10 more scans gives no repeat.
- Multi-key: hold keys 1 and 4 together for 5 scans. Require no acceptance and `entry` unchanged.
- Overrun/ack: with `data_ready`=1 holding 6A, enter key 5. Require `overrun`=1 and `bus_out` still 6A. Pulse `ack` in the cycle key 7 is accepted. Require `data_ready`=0, `overrun`=0, and `entry`=8'h70.
- Reset mid-entry: after the first nibble (`entry`=8'h90), assert `rst` for one cycle mid-row-2. Require `entry`=0, `nib`=0, and `rows`=1110 on the next cycle.

Source files
------------

// File: rtl/keypad_input.sv
// keypad_input: scans a 4x4 active-low hex keypad, debounces whole-matrix
// snapshots, assembles two accepted keys into a byte (high nibble first) and
// presents it on a CPU bus that can be wire-ORed with other sources.
module keypad_input #(
  parameter int SCAN_WAIT      = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       enable,
  input  logic       ack,
  output logic [7:0] bus_out,
  output logic       data_ready,
  output logic       overrun
);

  localparam int CW = (SCAN_WAIT > 1) ? $clog2(SCAN_WAIT) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_WAIT - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  // True when exactly one key is down in the snapshot.
  function automatic logic one_key(input logic [15:0] m);
    return (m != 16'h0000) && ((m & (m - 16'h0001)) == 16'h0000);
  endfunction

  // Key code (row*4 + col) of the highest set snapshot bit.
  function automatic logic [3:0] key_of(input logic [15:0] m);
    logic [3:0] k;
    k = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        k = 4'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

  logic [3:0]    col_meta_r;
  logic [3:0]    col_sync_r;
  logic [CW-1:0] dwell_r;
  logic [1:0]    row_r;
  logic [3:0]    rows_r;
  logic [15:0]   snap_r;
  logic [15:0]   prev_snap_r;
  logic [SW-1:0] stable_r;
  state_t        state_r;
  logic [7:0]    entry_r;
  logic          nib_r;
  logic          data_ready_r;
  logic          overrun_r;

  logic [3:0]    col_pressed_s;
  logic          sample_s;
  logic          scan_end_s;
  logic [15:0]   snap_fill_s;
  logic [SW-1:0] stable_next_s;
  logic          settled_s;
  logic          accept_s;
  logic          release_s;
  logic [3:0]    key_s;
  logic          ack_take_s;

  // Scan timing, the snapshot including the row being sampled, and debounce decisions.
  always_comb begin
    col_pressed_s = ~col_sync_r;
    sample_s      = (dwell_r == DWELL_LAST);
    scan_end_s    = sample_s && (row_r == 2'd3);
    snap_fill_s   = snap_r;
    snap_fill_s[{row_r, 2'b00} +: 4] = col_pressed_s;
    if (snap_fill_s == prev_snap_r) begin
      if (stable_r == STABLE_MAX) begin
        stable_next_s = STABLE_MAX;
      end else begin
        stable_next_s = stable_r + SW'(1);
      end
    end else begin
      stable_next_s = SW'(1);
    end
    settled_s  = scan_end_s && (stable_next_s == STABLE_MAX);
    accept_s   = settled_s && (state_r == RELEASED) && one_key(snap_fill_s);
    release_s  = settled_s && (state_r == PRESSED) && (snap_fill_s == 16'h0000);
    key_s      = key_of(snap_fill_s);
    ack_take_s = ack && data_ready_r;
  end

  // Two-flop synchronizer for the asynchronous column lines (idle = released).
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= cols;
      col_sync_r <= col_meta_r;
    end
  end

  // Row dwell counter, row drive, per-row snapshot capture and stable-scan count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      dwell_r     <= '0;
      row_r       <= 2'd0;
      rows_r      <= 4'b1110;
      snap_r      <= 16'h0000;
      prev_snap_r <= 16'h0000;
      stable_r    <= '0;
    end else if (sample_s) begin
      dwell_r <= '0;
      snap_r  <= snap_fill_s;
      row_r   <= row_r + 2'd1;
      case (row_r)
        2'd0:    rows_r <= 4'b1101;
        2'd1:    rows_r <= 4'b1011;
        2'd2:    rows_r <= 4'b0111;
        default: rows_r <= 4'b1110;
      endcase
      if (scan_end_s) begin
        prev_snap_r <= snap_fill_s;
        stable_r    <= stable_next_s;
      end else begin
        prev_snap_r <= prev_snap_r;
        stable_r    <= stable_r;
      end
    end else begin
      dwell_r <= dwell_r + CW'(1);
    end
  end

  // Debounce FSM: one acceptance per press, full release needed before the next.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= RELEASED;
    end else begin
      case (state_r)
        RELEASED: state_r <= accept_s ? PRESSED : RELEASED;
        PRESSED:  state_r <= release_s ? RELEASED : PRESSED;
        default:  state_r <= RELEASED;
      endcase
    end
  end

  // Byte assembly; ack is applied before a coincident acceptance.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      entry_r      <= 8'h00;
      nib_r        <= 1'b0;
      data_ready_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (ack_take_s) begin
      data_ready_r <= 1'b0;
      overrun_r    <= 1'b0;
      if (accept_s) begin
        entry_r <= {key_s, 4'h0};
        nib_r   <= 1'b1;
      end else begin
        entry_r <= 8'h00;
        nib_r   <= 1'b0;
      end
    end else if (accept_s) begin
      if (data_ready_r) begin
        overrun_r <= 1'b1;
      end else if (!nib_r) begin
        entry_r <= {key_s, 4'h0};
        nib_r   <= 1'b1;
      end else begin
        entry_r[3:0] <= key_s;
        nib_r        <= 1'b0;
        data_ready_r <= 1'b1;
      end
    end else begin
      entry_r <= entry_r;
    end
  end

  // Bus drive is combinational so it can be ORed with other bus sources.
  always_comb begin
    if (enable) begin
      bus_out = entry_r;
    end else begin
      bus_out = 8'h00;
    end
  end

  assign rows       = rows_r;
  assign data_ready = data_ready_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_keypad_input.sv
// tb_keypad_input: keypad matrix model, table-driven byte entries with a
// scoreboard of expected bytes, and hand-written multi-cycle corner cases.
module tb_keypad_input;

  localparam int SW_T = 4;
  localparam int SCAN = 4 * SW_T;

  logic       sys_clk;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       enable;
  logic       ack;
  logic [7:0] bus_out;
  logic       data_ready;
  logic       overrun;

  logic [15:0] keys;
  int          checks;
  int          failures;
  int          acc_count;
  logic        dr_q;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[5];
  logic [3:0] row_seq[5];

  keypad_input #(.SCAN_WAIT(SW_T), .DEBOUNCE_SCANS(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .rows(rows), .cols(cols), .enable(enable),
    .ack(ack), .bus_out(bus_out), .data_ready(data_ready), .overrun(overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Matrix model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acceptance counter, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (dut.accept_s === 1'b1) acc_count <= acc_count + 1;
  end

  // Scoreboard: each new byte is compared against the oldest expected byte.
  always @(negedge sys_clk) begin
    dr_q <= data_ready;
    if (!rst && data_ready === 1'b1 && dr_q === 1'b0) begin
      if (exp_q.size() > 0) check("sb_byte", 32'(bus_out), 32'(exp_q.pop_front()));
      else check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
    end
  end

  // Press a key and stop at the mid-cycle where the DUT accepts it (bounded).
  task automatic enter_key(input logic [3:0] key, output logic seen);
    keys = 16'h0001 << key;
    seen = 1'b0;
    for (int i = 0; i < 5 * SCAN; i++) begin
      @(negedge sys_clk);
      if (dut.accept_s === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_keys();
    keys = 16'h0000;
    repeat (4 * SCAN) @(negedge sys_clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge sys_clk);
    ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic [3:0] prev_rows;
    logic       found;
    int         a0;

    vecs[0] = '{hi: 4'h6, lo: 4'hA, exp: 8'h6A};
    vecs[1] = '{hi: 4'h0, lo: 4'hF, exp: 8'h0F};
    vecs[2] = '{hi: 4'hF, lo: 4'h0, exp: 8'hF0};
    vecs[3] = '{hi: 4'h3, lo: 4'hC, exp: 8'h3C};
    vecs[4] = '{hi: 4'h9, lo: 4'h5, exp: 8'h95};
    row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011;
    row_seq[3] = 4'b0111; row_seq[4] = 4'b1110;

    checks = 0; failures = 0; acc_count = 0; dr_q = 1'b0;
    rst = 1'b1; enable = 1'b1; ack = 1'b0; keys = 16'h0000;

    // Reset state and row stepping.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_rows", 32'(rows), 32'(4'b1110));
    check("rst_data_ready", 32'(data_ready), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_bus", 32'(bus_out), 32'h00);
    rst = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("rows_step0", 32'(rows), 32'(row_seq[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rows_step", 32'(rows), 32'(row_seq[i]));
    end

    // Table-driven byte entries.
    for (int v = 0; v < 5; v++) begin
      enter_key(vecs[v].hi, seen);
      check("hi_accepted", 32'(seen), 32'd1);
      @(negedge sys_clk);
      check("hi_partial_bus", 32'(bus_out), 32'({vecs[v].hi, 4'h0}));
      check("hi_not_ready", 32'(data_ready), 32'd0);
      release_keys();
      exp_q.push_back(vecs[v].exp);
      enter_key(vecs[v].lo, seen);
      check("lo_accepted", 32'(seen), 32'd1);
      @(negedge sys_clk);
      check("lo_ready", 32'(data_ready), 32'd1);
      check("lo_bus", 32'(bus_out), 32'(vecs[v].exp));
      release_keys();
      pulse_ack();
      check("ack_ready_clear", 32'(data_ready), 32'd0);
      check("ack_entry_clear", 32'(bus_out), 32'h00);
    end

    // Bounce on key 3, aligned to the start of row 0.
    found = 1'b0;
    prev_rows = rows;
    for (int i = 0; i < 4 * SCAN; i++) begin
      @(negedge sys_clk);
      if (rows == 4'b1110 && prev_rows == 4'b0111) begin
        found = 1'b1;
        break;
      end
      prev_rows = rows;
    end
    check("align_row0", 32'(found), 32'd1);
    a0 = acc_count;
    for (int i = 0; i < 13; i++) begin
      keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (5) @(negedge sys_clk);
    end
    check("bounce_no_accept", 32'(acc_count), 32'(a0));
    keys = 16'h0008;
    repeat (12 * SCAN) @(negedge sys_clk);
    check("bounce_one_accept", 32'(acc_count), 32'(a0 + 1));
    check("bounce_entry", 32'(bus_out), 32'h30);
    release_keys();

    // Multi-key snapshot must never be accepted.
    a0 = acc_count;
    keys = 16'h0012;
    repeat (5 * SCAN) @(negedge sys_clk);
    check("multi_no_accept", 32'(acc_count), 32'(a0));
    check("multi_entry_kept", 32'(bus_out), 32'h30);
    release_keys();

    // ack without a held byte does nothing; enable gates the bus.
    pulse_ack();
    check("idle_ack_entry", 32'(bus_out), 32'h30);
    enable = 1'b0;
    #1;
    check("enable_low_bus", 32'(bus_out), 32'h00);
    enable = 1'b1;
    exp_q.push_back(8'h35);
    enter_key(4'h5, seen);
    check("k5_accepted", 32'(seen), 32'd1);
    @(negedge sys_clk);
    check("k35_ready", 32'(data_ready), 32'd1);
    release_keys();
    pulse_ack();

    // Overrun, then ack coinciding with an acceptance.
    exp_q.push_back(8'h6A);
    enter_key(4'h6, seen);
    release_keys();
    enter_key(4'hA, seen);
    release_keys();
    check("ovr_pre_ready", 32'(data_ready), 32'd1);
    enter_key(4'h5, seen);
    check("ovr_key_seen", 32'(seen), 32'd1);
    @(negedge sys_clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_ready_kept", 32'(data_ready), 32'd1);
    check("ovr_bus_kept", 32'(bus_out), 32'h6A);
    release_keys();
    keys = 16'h0080;
    seen = 1'b0;
    for (int i = 0; i < 5 * SCAN; i++) begin
      @(negedge sys_clk);
      if (dut.accept_s === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("k7_seen", 32'(seen), 32'd1);
    pulse_ack();
    check("ackacc_ready", 32'(data_ready), 32'd0);
    check("ackacc_overrun", 32'(overrun), 32'd0);
    check("ackacc_entry", 32'(bus_out), 32'h70);
    release_keys();

    // Finish that byte, then reset in the middle of the next one.
    exp_q.push_back(8'h79);
    enter_key(4'h9, seen);
    release_keys();
    pulse_ack();
    enter_key(4'h9, seen);
    @(negedge sys_clk);
    check("mid_entry_90", 32'(bus_out), 32'h90);
    release_keys();
    found = 1'b0;
    for (int i = 0; i < 2 * SCAN; i++) begin
      @(negedge sys_clk);
      if (rows == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    check("found_row2", 32'(found), 32'd1);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check("mid_rst_entry", 32'(bus_out), 32'h00);
    check("mid_rst_nib", 32'(dut.nib_r), 32'd0);
    check("mid_rst_rows", 32'(rows), 32'(4'b1110));
    check("mid_rst_ready", 32'(data_ready), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
